// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: quadrature phase type, PS2 packet field positions, saturating add and phase step helpers
package ps2_mouse_pkg;
    typedef enum logic [1:0] {
        PH00 = 2'b00,
        PH10 = 2'b10,
        PH11 = 2'b11,
        PH01 = 2'b01
    } phase_t;

    localparam int P_STB  = 24;
    localparam int P_Y_HI = 23;
    localparam int P_Y_LO = 16;
    localparam int P_X_HI = 15;
    localparam int P_X_LO = 8;
    localparam int P_YOVR = 7;
    localparam int P_XOVR = 6;
    localparam int P_YSGN = 5;
    localparam int P_XSGN = 4;
    localparam int P_BTN_HI = 2;

    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint s, hi;
        s = a + b;
        hi = (longint'(1) <<< (w - 1)) - 1;
        return s > hi ? hi : s < -hi - 1 ? -hi - 1 : s;
    endfunction

    // Forward order 00->10->11->01; rev walks it backwards.
    function automatic phase_t next_phase(input phase_t p, input logic rev);
        return rev ? (p == PH00 ? PH01 : p == PH01 ? PH11 : p == PH11 ? PH10 : PH00)
                   : (p == PH00 ? PH10 : p == PH10 ? PH11 : p == PH11 ? PH01 : PH00);
    endfunction
endpackage

// File: rtl/ps2_quad_mouse_if.sv
// ps2_quad_mouse_if: PS2 packet in, Mac quadrature pairs and button out
interface ps2_quad_mouse_if;
    logic [24:0] ps2_mouse;
    logic        x1;
    logic        x2;
    logic        y1;
    logic        y2;
    logic        button;

    modport master (output ps2_mouse, input x1, x2, y1, y2, button);
    modport slave  (input ps2_mouse, output x1, x2, y1, y2, button);
endinterface

// File: rtl/ps2_quad_axis.sv
// ps2_quad_axis: per-axis delta decode, saturating accumulator and quadrature phase FSM (PS2_MOUSE_ACCEL_EN doubles large deltas)
module ps2_quad_axis
    import ps2_mouse_pkg::*;
#(
    parameter int ACC_W     = 10,
    parameter bit INV       = 1'b0,
    parameter int ACCEL_THR = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe,
    input  logic       tick,
    input  logic [7:0] move,
    input  logic       sgn,
    input  logic       ovr,
    output logic       q1,
    output logic       q2
);
    if (ACC_W < 10 || ACCEL_THR < 1) begin : g_bad_cfg
        $error("ps2_quad_axis: ACC_W must be >= 10 and ACCEL_THR >= 1");
    end

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_n;
    logic signed [9:0]       raw;
    longint                  d;
    longint                  s;
    logic                    step;
    phase_t                  ph;

    assign {q1, q2} = ph;

    always_comb begin
        raw = ovr ? (sgn ? -10'sd256 : 10'sd255) : $signed({sgn, sgn, move});
        d = INV ? sat_add(0, -longint'(raw), ACC_W) : longint'(raw);
`ifdef PS2_MOUSE_ACCEL_EN
        d = (d >= ACCEL_THR || d <= -ACCEL_THR) ? sat_add(d, d, ACC_W) : d;
`endif
        step = tick && acc != 0;
        s = step ? (acc[ACC_W-1] ? -64'sd1 : 64'sd1) : 64'sd0;
        acc_n = ACC_W'(sat_add(longint'(acc) - s, strobe ? d : 64'sd0, ACC_W));
    end

    // Phase direction comes from the accumulator sign before this cycle's update.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            ph  <= PH00;
        end else begin
            acc <= acc_n;
            if (step) ph <= next_phase(ph, acc[ACC_W-1]);
        end
    end
endmodule

// File: rtl/ps2_quad_mouse.sv
// ps2_quad_mouse: PS2 mouse packets to Mac quadrature/button outputs (optional PS2_MOUSE_ACCEL_EN acceleration)
module ps2_quad_mouse
    import ps2_mouse_pkg::*;
#(
    parameter int       ACC_W     = 10,
    parameter int       DIV_W     = 12,
    parameter bit       Y_INV     = 1'b0,
    parameter bit [2:0] BTN_MASK  = 3'b111,
    parameter int       ACCEL_THR = 8
) (
    input logic               clk,
    input logic               reset,
    input logic               ce,
    ps2_quad_mouse_if.slave   bus
);
    logic             stb_q;
    logic             strobe;
    logic             tick;
    logic [DIV_W-1:0] clkdiv;
    logic             unused_bit;

    assign strobe     = bus.ps2_mouse[P_STB] ^ stb_q;
    assign tick       = ce && clkdiv == '0;
    assign unused_bit = bus.ps2_mouse[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_q      <= 1'b0;
            clkdiv     <= '0;
            bus.button <= 1'b1;
        end else begin
            stb_q <= bus.ps2_mouse[P_STB];
            if (ce) clkdiv <= clkdiv + 1'b1;
            if (strobe) bus.button <= ~|(bus.ps2_mouse[P_BTN_HI:0] & BTN_MASK);
        end
    end

    ps2_quad_axis #(.ACC_W(ACC_W), .INV(1'b0), .ACCEL_THR(ACCEL_THR)) u_x (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .tick   (tick),
        .move   (bus.ps2_mouse[P_X_HI:P_X_LO]),
        .sgn    (bus.ps2_mouse[P_XSGN]),
        .ovr    (bus.ps2_mouse[P_XOVR]),
        .q1     (bus.x1),
        .q2     (bus.x2)
    );

    ps2_quad_axis #(.ACC_W(ACC_W), .INV(Y_INV), .ACCEL_THR(ACCEL_THR)) u_y (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .tick   (tick),
        .move   (bus.ps2_mouse[P_Y_HI:P_Y_LO]),
        .sgn    (bus.ps2_mouse[P_YSGN]),
        .ovr    (bus.ps2_mouse[P_YOVR]),
        .q1     (bus.y1),
        .q2     (bus.y2)
    );
endmodule

// File: tb/tb_ps2_quad_mouse.sv
// tb_ps2_quad_mouse: directed and random checks of ps2_quad_mouse against a cycle reference model
module tb_ps2_quad_mouse;
    localparam int       ACC_W = 10;
    localparam int       DIV_W = 2;
    localparam int       THR   = 8;
    localparam bit       Y_INV = 1'b1;
    localparam bit [2:0] MASK  = 3'b110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;

    ps2_quad_mouse_if bus();

    ps2_quad_mouse #(
        .ACC_W(ACC_W), .DIV_W(DIV_W), .Y_INV(Y_INV), .BTN_MASK(MASK), .ACCEL_THR(THR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mx, my, px, py, mdiv, mstb;
    logic mbtn;
    bit last_tick;
    logic [1:0] ptab [4];

    function automatic int sat(input int v);
        int hi;
        hi = (1 << (ACC_W - 1)) - 1;
        return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
    endfunction

    function automatic int sgnf(input int v);
        return v > 0 ? 1 : v < 0 ? -1 : 0;
    endfunction

    function automatic int delta(input logic [7:0] mv, input logic s, input logic o, input bit inv);
        int d;
        d = o ? (s ? -256 : 255) : (s ? int'(mv) - 256 : int'(mv));
        if (inv) d = sat(-d);
`ifdef PS2_MOUSE_ACCEL_EN
        if (d >= THR || d <= -THR) d = sat(2 * d);
`endif
        return d;
    endfunction

    task automatic model();
        logic [24:0] p;
        bit stb, tk;
        int sx, sy;
        p = bus.ps2_mouse;
        if (reset) begin
            mx = 0; my = 0; px = 0; py = 0; mdiv = 0; mstb = 0; mbtn = 1'b1; last_tick = 0;
            return;
        end
        stb = (int'(p[24]) != mstb);
        tk = ce && mdiv == 0;
        last_tick = tk;
        sx = tk ? sgnf(mx) : 0;
        sy = tk ? sgnf(my) : 0;
        px = (px + sx + 4) % 4;
        py = (py + sy + 4) % 4;
        mx = sat(mx - sx + (stb ? delta(p[15:8], p[4], p[6], 1'b0) : 0));
        my = sat(my - sy + (stb ? delta(p[23:16], p[5], p[7], Y_INV) : 0));
        mstb = int'(p[24]);
        if (ce) mdiv = (mdiv + 1) % (1 << DIV_W);
        if (stb) mbtn = ~|(p[2:0] & MASK);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
        chk("x_quad", {bus.x1, bus.x2}, ptab[px]);
        chk("y_quad", {bus.y1, bus.y2}, ptab[py]);
        chk("button", bus.button, mbtn);
        chk("x_acc", dut.u_x.acc, mx);
        chk("y_acc", dut.u_y.acc, my);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] xm, input logic [7:0] ym, input logic [7:0] flags);
        bus.ps2_mouse = {~bus.ps2_mouse[24], ym, xm, flags};
    endtask

    task automatic tick();
        int n;
        n = 0;
        ce = 1'b1;
        do begin
            step();
            n++;
        end while (!last_tick && n < 8);
        ce = 1'b0;
        chk("tick_seen", last_tick, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ps2_mouse = '0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] f;
        ptab[0] = 2'b00; ptab[1] = 2'b10; ptab[2] = 2'b11; ptab[3] = 2'b01;
        bus.ps2_mouse = '0;
        reset = 1'b1;
        steps(3);
        chk("rst_button", bus.button, 1);
        chk("rst_xq", {bus.x1, bus.x2}, 0);
        chk("rst_yq", {bus.y1, bus.y2}, 0);
        reset = 1'b0;
        steps(2);

        send(8'd3, 8'd0, 8'h00);
        steps(10);
        chk("fwd_acc_hold", dut.u_x.acc, 3);
        chk("fwd_static", {bus.x1, bus.x2}, 0);
        tick();
        chk("fwd_ph1", {bus.x1, bus.x2}, 2'b10);
        tick();
        chk("fwd_ph2", {bus.x1, bus.x2}, 2'b11);
        tick();
        chk("fwd_ph3", {bus.x1, bus.x2}, 2'b01);
        chk("fwd_acc_zero", dut.u_x.acc, 0);
        tick();
        chk("fwd_idle", {bus.x1, bus.x2}, 2'b01);

        do_reset();
        send(8'hFE, 8'd0, 8'h10);
        step();
        tick();
        chk("rev_ph1", {bus.x1, bus.x2}, 2'b01);
        tick();
        chk("rev_ph2", {bus.x1, bus.x2}, 2'b11);
        chk("rev_acc_zero", dut.u_x.acc, 0);

        do_reset();
        repeat (4) begin
            send(8'd0, 8'd0, 8'h40);
            step();
        end
        chk("sat_pos", dut.u_x.acc, 511);

        do_reset();
        send(8'd5, 8'd0, 8'h00);
        steps(2);
        chk("coin_pre", dut.u_x.acc, 5);
        send(8'd4, 8'd0, 8'h00);
        ce = 1'b1;
        step();
        ce = 1'b0;
        chk("coin_acc", dut.u_x.acc, 8);
        chk("coin_ph", {bus.x1, bus.x2}, 2'b10);

        send(8'd0, 8'd0, 8'h01);
        step();
        chk("btn_masked", bus.button, 1);
        send(8'd0, 8'd0, 8'h02);
        step();
        chk("btn_right", bus.button, 0);
        reset = 1'b1;
        step();
        chk("mid_rst_btn", bus.button, 1);
        chk("mid_rst_xq", {bus.x1, bus.x2}, 0);
        chk("mid_rst_acc", dut.u_x.acc, 0);
        reset = 1'b0;
        step();

        do_reset();
        send(8'd0, 8'd10, 8'h00);
        step();
`ifdef PS2_MOUSE_ACCEL_EN
        chk("yinv_acc", dut.u_y.acc, -20);
`else
        chk("yinv_acc", dut.u_y.acc, -10);
`endif

        do_reset();
        repeat (600) begin
            ce = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 5) == 0) begin
                f = 8'($urandom);
                if ($urandom_range(0, 7) != 0) f[7:6] = 2'b00;
                send(8'($urandom), 8'($urandom), f);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_quad_mouse.md
PS2_QUAD_MOUSE -- requirements
Module: ps2_quad_mouse

Interface
REQ-001 Parameter ACC_W, default 10: signed accumulator width per axis, minimum 10.
REQ-002 Parameter DIV_W, default 12: step-tick divider width.
REQ-003 Parameter Y_INV, default 0: when 1, Y delta is negated before accumulation.
REQ-004 Parameter BTN_MASK, default 3'b111: selects which of L/R/M drive button.
REQ-005 Parameter ACCEL_THR, default 8: acceleration threshold on |delta|.
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ce  in  1  clock enable for the step divider only.
REQ-009 ps2_mouse  in  25  [24] toggle strobe, [23:16] Y move, [15:8] X move, [7] YOVR, [6] XOVR, [5] YSGN, [4] XSGN, [2:0] M/R/L.
REQ-010 x1, x2, y1, y2  out  1 each  quadrature pairs toward the Mac.
REQ-011 button  out  1  active-low, masked button OR.

Function
REQ-012 strobe SHALL be 1 for exactly one cycle whenever ps2_mouse[24] differs from its value registered on the previous clk.
REQ-013 Per axis, delta SHALL be the 9-bit value {SGN, MOVE} sign-extended to ACC_W; if OVR is set, delta SHALL be forced to +255 (SGN=0) or -256 (SGN=1).
REQ-014 clkdiv SHALL increment by 1 on each ce cycle and wrap modulo 2^DIV_W; tick = ce and clkdiv==0.
REQ-015 On tick with acc!=0, the axis SHALL advance one quadrature phase: phase sequence (x1,x2) 00->10->11->01->00 for acc>0, reverse order for acc<0.
REQ-016 On tick with acc!=0, acc SHALL move one unit toward zero; on tick with acc==0, outputs and acc SHALL hold.
REQ-017 On strobe, acc SHALL become sat(acc + delta), saturating at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)); the delta is never discarded.
REQ-018 Strobe and tick in the same cycle: acc SHALL become sat(acc - sign(acc) + delta), and the phase step SHALL use the sign of acc before update.
REQ-019 Y axis SHALL behave identically to X, using Y fields, with delta negated (then saturated) when Y_INV=1.
REQ-020 On strobe, button SHALL become ~|(ps2_mouse[2:0] & BTN_MASK); otherwise it holds.
REQ-021 Quadrature outputs SHALL be registered; the first step occurs at the first tick after the strobe cycle (minimum latency 1 clk).

Reset
REQ-022 While reset is high: x1=x2=y1=y2=0, button=1, both acc=0, both phases=00, clkdiv=0, registered strobe bit=0.
REQ-023 Reset SHALL override a simultaneous strobe and tick; a packet strobed during reset is lost.

Configuration
REQ-024 With macro PS2_MOUSE_ACCEL_EN defined, a delta with |delta| >= ACCEL_THR SHALL be doubled (saturated to ACC_W) before accumulation; smaller deltas are unscaled.
REQ-025 Without PS2_MOUSE_ACCEL_EN, delta SHALL be accumulated unscaled and the ACCEL_THR logic SHALL not be synthesised.

Structure
REQ-026 Package ps2_mouse_pkg SHALL hold the quadrature phase type (4 states), the PS2 packet field bit positions, and the saturating-add function.
REQ-027 Sub-module ps2_quad_axis (delta decode, accumulator, phase FSM, outputs) SHALL be instantiated once per axis; divider, strobe and button logic stay in the top level.

Verification
REQ-028 Strobe with X=+3, no ce for 10 clk -> xacc=3, x1/x2 static; then 3 ticks -> (x1,x2) 10,11,01 and xacc=0; a 4th tick -> no change.
REQ-029 Strobe with XSGN=1, X=0xFE (-2) -> two ticks give (x1,x2) 01 then 11; xacc returns to 0.
REQ-030 ACC_W=10, four strobes of XOVR=1, XSGN=0 -> xacc saturates at +511, no wrap to negative.
REQ-031 Strobe coincident with tick while xacc=+5, delta=+4 -> xacc=8, one forward phase step.
REQ-032 Buttons L=1 with BTN_MASK=3'b110 -> button stays 1; R=1 -> button=0; reset mid-stream -> all outputs to reset values next clk.
REQ-033 With PS2_MOUSE_ACCEL_EN, Y=+10, Y_INV=1 -> yacc=-20; without the macro -> yacc=-10.
